// File: rtl/lc3_microsequencer_if.sv
// Bundles the microinstruction fields, datapath status bits and the
// registered control-store state of the LC-3 microsequencer.
interface lc3_microsequencer_if;
   logic [5:0] J;
   logic [2:0] cond;
   logic       IRD;
   logic [4:0] IR;
   logic       INT;
   logic       R;
   logic       BEN;
   logic       PSR;
   logic [5:0] controlst;

   modport master (
      output J, cond, IRD, IR, INT, R, BEN, PSR,
      input  controlst
   );

   modport slave (
      input  J, cond, IRD, IR, INT, R, BEN, PSR,
      output controlst
   );
endinterface

// File: rtl/lc3_microsequencer.sv
// LC-3 next-microinstruction address generator: opcode dispatch or J field
// with one condition-selected bit ORed in, held in a 6-bit state register.
module lc3_microsequencer (
   input  logic                 clk,
   input  logic                 rst_n,
   lc3_microsequencer_if.slave  seq
);

   localparam logic [5:0] FETCH_STATE = 6'd18;

   logic [5:0] nxt_s;
   logic [5:0] controlst_r;

   // Next-state select; only the input chosen by cond is ever read so an
   // unknown value on any other condition input cannot reach nxt_s.
   always_comb begin
      nxt_s = seq.J;
      if (seq.IRD) begin
         nxt_s = {2'b00, seq.IR[4:1]};
      end else begin
         case (seq.cond)
            3'b000:  nxt_s = seq.J;
            3'b001:  nxt_s[1] = seq.J[1] | seq.R;
            3'b010:  nxt_s[0] = seq.J[0] | seq.IR[0];
            3'b011:  nxt_s[4] = seq.J[4] | seq.INT;
            3'b100:  nxt_s[2] = seq.J[2] | seq.BEN;
            3'b101:  nxt_s[3] = seq.J[3] | seq.PSR;
            default: nxt_s = seq.J;
         endcase
      end
   end

   // State register with synchronous active-low reset to the fetch state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         controlst_r <= FETCH_STATE;
      end else begin
         controlst_r <= nxt_s;
      end
   end

   assign seq.controlst = controlst_r;

endmodule

// File: tb/tb_lc3_microsequencer.sv
// Scoreboard bench: stimulus pushes hand-computed expected states, a monitor
// pops and compares one entry after every rising edge.
module tb_lc3_microsequencer;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   lc3_microsequencer_if seq_if ();

   lc3_microsequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .seq   (seq_if.slave)
   );

   logic [5:0] exp_q[$];
   string      name_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expected entry per edge after stimulus began
   initial begin
      logic [5:0] e;
      string      n;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total = total + 1;
            if ($isunknown(seq_if.controlst) || seq_if.controlst !== e) begin
               bad = bad + 1;
               $display("FAIL %s: got %0d expected %0d", n, seq_if.controlst, e);
            end
         end
      end
   end

   task automatic step(input logic rst, input logic ird, input logic [4:0] ir,
                       input logic [5:0] j, input logic [2:0] c,
                       input logic intr, input logic r, input logic ben,
                       input logic psr, input logic [5:0] e, input string n);
      @(negedge clk);
      rst_n          = rst;
      seq_if.IRD     = ird;
      seq_if.IR      = ir;
      seq_if.J       = j;
      seq_if.cond    = c;
      seq_if.INT     = intr;
      seq_if.R       = r;
      seq_if.BEN     = ben;
      seq_if.PSR     = psr;
      exp_q.push_back(e);
      name_q.push_back(n);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b1;
      seq_if.IRD = 1'b0; seq_if.IR = 5'd0; seq_if.J = 6'd0; seq_if.cond = 3'd0;
      seq_if.INT = 1'b0; seq_if.R = 1'b0; seq_if.BEN = 1'b0; seq_if.PSR = 1'b0;

      //   rst   ird   ir         j           cond    int   r     ben   psr   exp
      step(1'b0, 1'b1, 5'b11010, 6'd0,      3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd18, "reset");
      step(1'b1, 1'b1, 5'b11010, 6'd0,      3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd13, "dispatch_after_reset");
      step(1'b1, 1'b0, 5'b00000, 6'd0,      3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 6'd16, "int_set");
      step(1'b1, 1'b0, 5'b00000, 6'd0,      3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  "int_clr");
      step(1'b1, 1'b0, 5'b00000, 6'd0,      3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 6'd2,  "r_set");
      step(1'b1, 1'b0, 5'b00000, 6'd0,      3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  "r_clr");
      step(1'b1, 1'b0, 5'b00001, 6'd0,      3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1,  "ir11_set");
      step(1'b1, 1'b0, 5'b00000, 6'd0,      3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  "ir11_clr");
      step(1'b1, 1'b0, 5'b00000, 6'd0,      3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 6'd4,  "ben_set");
      step(1'b1, 1'b0, 5'b00000, 6'd0,      3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  "ben_clr");
      step(1'b1, 1'b0, 5'b00000, 6'd0,      3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 6'd8,  "psr_set");
      step(1'b1, 1'b0, 5'b00000, 6'd0,      3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,  "psr_clr");
      step(1'b1, 1'b1, 5'b11010, 6'd0,      3'b101, 1'b0, 1'b0, 1'b0, 1'b1, 6'd13, "ird_psr1");
      step(1'b1, 1'b1, 5'b11010, 6'd0,      3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 6'd13, "ird_psr0");
      step(1'b1, 1'b0, 5'b00000, 6'b100001, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 6'd33, "or_keep_j0");
      step(1'b1, 1'b0, 5'b00000, 6'b010000, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 6'd16, "or_no_double");
      step(1'b1, 1'b0, 5'b00000, 6'b100000, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 6'd48, "int_with_j5");
      step(1'b1, 1'b0, 5'b11111, 6'd5,      3'b110, 1'b1, 1'b1, 1'b1, 1'b1, 6'd5,  "reserved_110");
      step(1'b1, 1'b0, 5'b11111, 6'd5,      3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 6'd5,  "reserved_111");
      step(1'b1, 1'b0, 5'b11111, 6'd0,      3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 6'd0,  "cond0_ignores_all");
      step(1'b1, 1'b0, 5'bxxxxx, 6'd0,      3'b001, 1'bx, 1'b1, 1'bx, 1'bx, 6'd2,  "x_isolation");
      step(1'b1, 1'b1, 5'b00110, 6'd0,      3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd3,  "dispatch_op3");
      step(1'b0, 1'b1, 5'b01010, 6'd7,      3'b011, 1'b1, 1'b1, 1'b1, 1'b1, 6'd18, "mid_reset");
      step(1'b1, 1'b0, 5'b00000, 6'd7,      3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd7,  "resume_after_reset");
      step(1'b1, 1'b1, 5'b11110, 6'd0,      3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 6'd15, "dispatch_max");

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #2;
      end
      if (exp_q.size() != 0) begin
         bad = bad + 1;
         total = total + 1;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
